// File: rtl/multi_timer.sv
// multi_timer: NUM_CH-channel programmable down-counter with a bus register
// file. Each channel has one-shot / auto-reload modes, an 8-bit prescaler, an
// interrupt mask and a sticky pending bit.
//
// Ports:
//   clk      system clock
//   reset    asynchronous active-low reset
//   addr     word address; addr[1:0] selects the register, addr[29:2] the channel
//   we       write strobe, sampled on the rising clock edge
//   byteen   byte-lane enables for writes
//   din      write data
//   dout     read data, combinational from addr
//   irq      per-channel interrupt (pending & IM)
//   irq_any  OR of all irq bits
//
// Register map (per channel, word offsets):
//   0 CTRL   [0]EN [2:1]MODE [3]IM [15:8]PRE
//   1 PRESET [WIDTH-1:0]
//   2 COUNT  read-only
//   3 STAT   [0]pending, write 1 to clear
module multi_timer #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [29:0]         addr,
  input  logic                we,
  input  logic [3:0]          byteen,
  input  logic [31:0]         din,
  output logic [31:0]         dout,
  output logic [NUM_CH-1:0]   irq,
  output logic                irq_any
);

  localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } state_e;

  state_e             state_q  [NUM_CH];
  logic [WIDTH-1:0]   preset_q [NUM_CH];
  logic [WIDTH-1:0]   count_q  [NUM_CH];
  logic [7:0]         pre_q    [NUM_CH];
  logic [7:0]         psc_q    [NUM_CH];
  logic [1:0]         mode_q   [NUM_CH];
  logic [NUM_CH-1:0]  en_q;
  logic [NUM_CH-1:0]  im_q;
  logic [NUM_CH-1:0]  pend_q;

  // The whole upper address field is the channel number, so any channel
  // beyond the implemented set (including high aliases) reads 0 and ignores
  // writes.
  logic [27:0]        ch_field;
  logic               ch_ok;
  logic [CHW-1:0]     ch_idx;
  logic [1:0]         reg_sel;
  logic [NUM_CH-1:0]  wsel;

  assign ch_field = addr[29:2];
  assign ch_ok    = (ch_field < 28'(NUM_CH));
  assign ch_idx   = ch_field[CHW-1:0];
  assign reg_sel  = addr[1:0];

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0] old,
                                                   input logic [31:0]      d,
                                                   input logic [3:0]       be);
    logic [31:0] w;
    w = zext(old);
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    end
    return w[WIDTH-1:0];
  endfunction

  always_comb begin
    wsel = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      wsel[c] = we && ch_ok && (32'(ch_idx) == c);
    end
  end

  // Bus writes are applied first and the FSM afterwards, so within one edge
  // the hardware's own updates take priority: pending set beats a W1C clear,
  // and the one-shot EN clear beats a simultaneous CTRL write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q   <= '0;
      im_q   <= '0;
      pend_q <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state_q[c]  <= ST_IDLE;
        preset_q[c] <= '0;
        count_q[c]  <= '0;
        pre_q[c]    <= '0;
        psc_q[c]    <= '0;
        mode_q[c]   <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (wsel[c]) begin
          case (reg_sel)
            2'd0: begin
              if (byteen[0]) begin
                en_q[c]   <= din[0];
                mode_q[c] <= din[2:1];
                im_q[c]   <= din[3];
              end
              if (byteen[1]) pre_q[c] <= din[15:8];
            end
            2'd1: preset_q[c] <= merge_lanes(preset_q[c], din, byteen);
            2'd3: if (byteen[0] && din[0]) pend_q[c] <= 1'b0;
            default: ;
          endcase
        end

        case (state_q[c])
          ST_IDLE: begin
            if (en_q[c]) state_q[c] <= ST_LOAD;
          end
          ST_LOAD: begin
            count_q[c] <= preset_q[c];
            psc_q[c]   <= '0;
            state_q[c] <= ST_CNT;
          end
          ST_CNT: begin
            if (!en_q[c]) begin
              state_q[c] <= ST_IDLE;
            end else if (count_q[c] == '0) begin
              pend_q[c]  <= 1'b1;
              state_q[c] <= ST_INT;
            end else if (psc_q[c] == pre_q[c]) begin
              psc_q[c]   <= '0;
              count_q[c] <= count_q[c] - WIDTH'(1);
              if (count_q[c] == WIDTH'(1)) begin
                pend_q[c]  <= 1'b1;
                state_q[c] <= ST_INT;
              end
            end else begin
              psc_q[c] <= psc_q[c] + 8'd1;
            end
          end
          ST_INT: begin
            if (mode_q[c] == 2'b01) begin
              state_q[c] <= ST_LOAD;
            end else begin
              en_q[c]    <= 1'b0;
              state_q[c] <= ST_IDLE;
            end
          end
          default: state_q[c] <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    dout = '0;
    if (ch_ok) begin
      case (reg_sel)
        2'd0:    dout = {16'h0, pre_q[ch_idx], 4'h0, im_q[ch_idx], mode_q[ch_idx], en_q[ch_idx]};
        2'd1:    dout = zext(preset_q[ch_idx]);
        2'd2:    dout = zext(count_q[ch_idx]);
        default: dout = {31'h0, pend_q[ch_idx]};
      endcase
    end
  end

  assign irq     = pend_q & im_q;
  assign irq_any = |irq;

endmodule

// File: tb/tb_multi_timer.sv
// Testbench for multi_timer (3 channels, 16-bit counters). Register reads are
// pushed with their expected value into a scoreboard queue; a monitor process
// samples dout/irq on each read strobe and compares. Expected values come from
// a closed-form model of a timer run: period T, count as a function of the
// number of edges since EN was written, and pending from set/clear edge times.
module tb_multi_timer;

  localparam int NCH = 3;
  localparam int W   = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [29:0]     addr;
  logic            we;
  logic [3:0]      byteen;
  logic [31:0]     din;
  logic [31:0]     dout;
  logic [NCH-1:0]  irq;
  logic            irq_any;

  multi_timer #(.NUM_CH(NCH), .WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .we      (we),
    .byteen  (byteen),
    .din     (din),
    .dout    (dout),
    .irq     (irq),
    .irq_any (irq_any)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [31:0]    dout;
    logic [NCH-1:0] irq;
    string          name;
  } exp_t;

  exp_t sbq[$];
  event rd_ev;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Model of the channel currently running.
  int         m_ch, m_P, m_R, m_T, m_e0, m_clr, m_pre;
  bit         m_auto, m_im;
  logic [1:0] m_mode;

  always @(rd_ev) begin
    exp_t e;
    n_vec++;
    if (sbq.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard: read strobe with no expected entry (dout=%h)", dout);
    end else begin
      e = sbq.pop_front();
      if (dout !== e.dout || irq !== e.irq || irq_any !== (|e.irq)) begin
        n_err++;
        $display("FAIL %s: got dout=%h irq=%b irq_any=%b, expected dout=%h irq=%b irq_any=%b",
                 e.name, dout, irq, irq_any, e.dout, e.irq, |e.irq);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wr(input int ch, input int rg, input logic [31:0] d, input logic [3:0] be);
    addr   = 30'((ch << 2) | rg);
    din    = d;
    byteen = be;
    we     = 1'b1;
    tick();
    we     = 1'b0;
    byteen = '0;
  endtask

  task automatic rd(input int ch, input int rg, input logic [31:0] ev,
                    input logic [NCH-1:0] ei, input string nm);
    exp_t e;
    we     = 1'b0;
    addr   = 30'((ch << 2) | rg);
    e.dout = ev;
    e.irq  = ei;
    e.name = nm;
    sbq.push_back(e);
    #1;
    ->rd_ev;
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  // k = number of edges since (and including) the edge that wrote EN.
  function automatic int exp_count(input int k);
    int d;
    if (!m_auto && k >= m_T) return 0;
    d = k % m_T;
    if (d < 2) return 0;
    return m_P - (d - 2) / m_R;
  endfunction

  function automatic bit exp_pend(input int k);
    int ls;
    if (k < m_T)     ls = -1;
    else if (m_auto) ls = (k / m_T) * m_T;
    else             ls = m_T;
    return (ls >= 0) && (ls >= m_clr);
  endfunction

  function automatic logic [NCH-1:0] exp_irq(input int k);
    logic [NCH-1:0] v;
    v = '0;
    v[m_ch] = exp_pend(k) & m_im;
    return v;
  endfunction

  function automatic logic [31:0] exp_ctrl(input int k);
    logic [31:0] v;
    v       = '0;
    v[0]    = m_auto || (k <= m_T);
    v[2:1]  = m_mode;
    v[3]    = m_im;
    v[15:8] = 8'(m_pre);
    return v;
  endfunction

  task automatic check(input int k);
    logic [NCH-1:0] ei;
    int r, oc;
    ei = exp_irq(k);
    rd(m_ch, 2, 32'(exp_count(k)), ei, "count");
    rd(m_ch, 3, {31'b0, exp_pend(k)}, ei, "stat");
    r = int'($urandom_range(0, 3));
    case (r)
      0: rd(m_ch, 0, exp_ctrl(k), ei, "ctrl");
      1: rd(m_ch, 1, 32'(m_P), ei, "preset");
      2: begin
        oc = (m_ch + 1 + int'($urandom_range(0, NCH - 2))) % NCH;
        rd(oc, int'($urandom_range(0, 3)), 32'h0, ei, "idle_channel");
      end
      default: rd(NCH, int'($urandom_range(0, 3)), 32'h0, ei, "out_of_range");
    endcase
  endtask

  // clr_at: -2 random STAT/COUNT writes, -1 none, otherwise W1C at that edge.
  task automatic run_timer(input int ch, input int P, input int pre, input logic [1:0] mode,
                           input bit im, input int len, input int clr_at);
    logic [31:0] d;
    logic [3:0]  be;
    do_reset();
    m_ch   = ch;
    m_P    = P;
    m_pre  = pre;
    m_R    = pre + 1;
    m_mode = mode;
    m_auto = (mode == 2'b01);
    m_im   = im;
    m_clr  = -1;
    m_T    = (P == 0) ? 3 : P * m_R + 2;
    d = $urandom();
    d[W-1:0] = W'(P);
    wr(ch, 1, d, 4'hF);
    d = $urandom();
    d[0]    = 1'b1;
    d[2:1]  = mode;
    d[3]    = im;
    d[15:8] = 8'(pre);
    wr(ch, 0, d, 4'hF);
    m_e0 = cyc;
    check(0);
    for (int i = 1; i <= len; i++) begin
      if (clr_at == i) begin
        wr(ch, 3, 32'h1, 4'h1);
        m_clr = i;
      end else if (clr_at == -2 && $urandom_range(0, 9) < 2) begin
        d  = $urandom();
        be = 4'($urandom());
        wr(ch, 3, d, be);
        if (be[0] && d[0]) m_clr = i;
      end else if (clr_at == -2 && $urandom_range(0, 9) == 0) begin
        wr(ch, 2, $urandom(), 4'hF);
      end else begin
        tick();
      end
      check(cyc - m_e0);
    end
  endtask

  initial begin
    int p, q, t;
    reset  = 1'b0;
    we     = 1'b0;
    byteen = '0;
    din    = '0;
    addr   = '0;
    m_ch = 0; m_P = 0; m_R = 1; m_T = 3; m_e0 = 0; m_clr = -1; m_pre = 0;
    m_auto = 1'b0; m_im = 1'b0; m_mode = 2'b00;
    #2;
    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < 4; r++)
        rd(c, r, 32'h0, '0, "reset_value");
    reset = 1'b1;

    // One-shot PRESET=5; pending at edge 7, cleared at edge 10.
    run_timer(0, 5, 0, 2'b00, 1'b1, 12, 10);
    // Auto-reload PRESET=3 on ch1; period 5, cleared between sets.
    run_timer(1, 3, 0, 2'b01, 1'b1, 17, 7);
    // Prescaler PRE=3, PRESET=2: pending at edge 10.
    run_timer(2, 2, 3, 2'b10, 1'b1, 12, -1);
    // IM=0: pending sets, irq stays low.
    run_timer(0, 2, 0, 2'b11, 1'b0, 6, -1);
    // PRESET=0: pending at edge 3; clear on that same edge loses.
    run_timer(1, 0, 0, 2'b00, 1'b1, 6, 3);

    // Byte lanes and read-only/width behaviour.
    do_reset();
    wr(0, 0, 32'h0000_0701, 4'b0010);
    rd(0, 0, 32'h0000_0700, '0, "ctrl_byteen_0010");
    tick(); tick(); tick();
    rd(0, 2, 32'h0, '0, "count_not_started");
    wr(0, 0, 32'hFFFF_FFFF, 4'b0000);
    rd(0, 0, 32'h0000_0700, '0, "ctrl_byteen_0000");
    wr(0, 1, 32'hFFFF_FFFF, 4'hF);
    rd(0, 1, 32'h0000_FFFF, '0, "preset_width_mask");
    wr(0, 1, 32'h1234_5600, 4'b0001);
    rd(0, 1, 32'h0000_FF00, '0, "preset_byte0_only");
    wr(0, 2, 32'h0000_0055, 4'hF);
    rd(0, 2, 32'h0, '0, "count_write_ignored");

    // CTRL write of EN=1 on the edge where the one-shot clears EN.
    run_timer(0, 1, 0, 2'b00, 1'b1, 3, -1);
    wr(0, 0, 32'h0000_0009, 4'h1);
    rd(0, 0, 32'h0000_0008, NCH'(1), "ctrl_hw_clear_wins");
    tick(); tick();
    rd(0, 0, 32'h0000_0008, NCH'(1), "ctrl_stays_idle");
    rd(0, 2, 32'h0, NCH'(1), "count_stopped_at_zero");
    wr(0, 3, 32'h1, 4'h1);
    rd(0, 3, 32'h0, '0, "stat_w1c");

    // Asynchronous reset between edges while counting with irq raised.
    run_timer(2, 2, 0, 2'b01, 1'b1, 6, -1);
    tick();
    reset = 1'b0;
    rd(2, 2, 32'h0, '0, "count_async_reset");
    rd(2, 0, 32'h0, '0, "ctrl_async_reset");
    rd(2, 3, 32'h0, '0, "stat_async_reset");
    rd(NCH, 0, 32'h0, '0, "out_of_range_in_reset");
    reset = 1'b1;

    for (int it = 0; it < 40; it++) begin
      p = int'($urandom_range(0, 6));
      q = int'($urandom_range(0, 2));
      t = (p == 0) ? 3 : p * (q + 1) + 2;
      run_timer(int'($urandom_range(0, NCH - 1)), p, q, 2'($urandom()), 1'($urandom()),
                int'($urandom_range(1, 2 * t + 4)), -2);
    end

    #5;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
